// File: rtl/quad_decoder.sv
// quad_decoder: quadrature steering receiver. Turns a 2-phase A/B signal
// into a wrapping position, step/dir pulses and held left/right levels.
//
// Parameters:
//   FILT_LEN  cycles a synchronized phase must stay changed (0 = no filter)
//   POS_W     position counter width
//   HOLD      cycles c_left/c_right stay high after the last counted step
//
// Ports:
//   CLK      in   core clock
//   Reset_n  in   asynchronous active-low reset
//   steerA   in   quadrature phase A (asynchronous)
//   steerB   in   quadrature phase B (asynchronous)
//   clr      in   synchronous clear of pos (wins over a coincident step)
//   pos      out  two's-complement position, wraps modulo 2^POS_W
//   step     out  1-cycle pulse per counted step
//   dir      out  direction of last counted step (1 = forward)
//   err      out  1-cycle pulse on a double (illegal) transition
//   c_right  out  held level after forward motion
//   c_left   out  held level after reverse motion
//
// Build option: define QUAD_X4_EN for x4 decode (every legal transition
// counts). Default is x1 decode: only 00->10 (+1) and 10->00 (-1) count.

module quad_decoder #(
   parameter int FILT_LEN = 4,
   parameter int POS_W    = 8,
   parameter int HOLD     = 45000
) (
   input  logic             CLK,
   input  logic             Reset_n,
   input  logic             steerA,
   input  logic             steerB,
   input  logic             clr,
   output logic [POS_W-1:0] pos,
   output logic             step,
   output logic             dir,
   output logic             err,
   output logic             c_right,
   output logic             c_left
);

   localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

   // Phase pairs are kept as {A,B}.
   logic [1:0]    sync1;
   logic [1:0]    sync2;
   logic [1:0]    filt;
   logic [1:0]    prev;
   logic          valid;
   logic          fwd;
   logic          rev;
   logic          ill;
   logic          cnt_fwd;
   logic          cnt_rev;
   logic [HW-1:0] hold_cnt;

   // Two-flop synchronizer per phase.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= {steerA, steerB};
         sync2 <= sync1;
      end
   end

   generate
      if (FILT_LEN == 0) begin : g_nofilt
         assign filt = sync2;
      end else begin : g_filt
         localparam int CW = $clog2(FILT_LEN + 1);
         for (genvar i = 0; i < 2; i++) begin : g_ph
            logic [CW-1:0] cnt;
            logic          f;
            // Accept a new level only after FILT_LEN consecutive
            // disagreeing samples; any bounce back restarts the count.
            always_ff @(posedge CLK or negedge Reset_n) begin
               if (!Reset_n) begin
                  cnt <= '0;
                  f   <= 1'b0;
               end else if (sync2[i] == f) begin
                  cnt <= '0;
               end else if (cnt == CW'(FILT_LEN - 1)) begin
                  cnt <= '0;
                  f   <= sync2[i];
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            assign filt[i] = f;
         end
      end
   endgenerate

   // Transition classification against the previous filtered state.
   always_comb begin
      fwd = 1'b0;
      rev = 1'b0;
      ill = 1'b0;
      if (valid) begin
         unique case ({prev, filt})
            4'b00_10, 4'b10_11,
            4'b11_01, 4'b01_00: fwd = 1'b1;
            4'b10_00, 4'b11_10,
            4'b01_11, 4'b00_01: rev = 1'b1;
            4'b00_11, 4'b11_00,
            4'b10_01, 4'b01_10: ill = 1'b1;
            default: ;
         endcase
      end
   end

`ifdef QUAD_X4_EN
   assign cnt_fwd = fwd;
   assign cnt_rev = rev;
`else
   // Only the 00<->10 edge counts; other legal moves just track state.
   assign cnt_fwd = fwd && (prev == 2'b00);
   assign cnt_rev = rev && (prev == 2'b10);
`endif

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         prev     <= '0;
         valid    <= 1'b0;
         pos      <= '0;
         step     <= 1'b0;
         dir      <= 1'b0;
         err      <= 1'b0;
         c_right  <= 1'b0;
         c_left   <= 1'b0;
         hold_cnt <= '0;
      end else begin
         // First sample after reset just primes prev (classifiers
         // are gated by valid, so it never counts).
         prev  <= filt;
         valid <= 1'b1;
         step  <= cnt_fwd | cnt_rev;
         err   <= ill;

         if (clr)
            pos <= '0;
         else if (cnt_fwd)
            pos <= pos + POS_W'(1);
         else if (cnt_rev)
            pos <= pos - POS_W'(1);

         if (cnt_fwd || cnt_rev)
            dir <= cnt_fwd;

         // Hold: load HOLD-1 on a step and drop on reaching 0, giving
         // exactly HOLD high cycles. A new step always replaces the
         // other direction, so both levels are never high together.
         if (cnt_fwd || cnt_rev) begin
            hold_cnt <= HW'(HOLD - 1);
            c_right  <= cnt_fwd;
            c_left   <= cnt_rev;
         end else if (c_right || c_left) begin
            if (hold_cnt == '0) begin
               c_right <= 1'b0;
               c_left  <= 1'b0;
            end else begin
               hold_cnt <= hold_cnt - HW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: directed scoreboard bench for quad_decoder
// (FILT_LEN=4, POS_W=8, HOLD=10); expectations follow QUAD_X4_EN.

module tb_quad_decoder;

`ifdef QUAD_X4_EN
   localparam bit X4 = 1'b1;
`else
   localparam bit X4 = 1'b0;
`endif
   localparam int LAT = 7;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       sa    = 1'b0;
   logic       sb    = 1'b0;
   logic       clr   = 1'b0;
   logic [7:0] pos;
   logic       step;
   logic       dir;
   logic       err;
   logic       c_right;
   logic       c_left;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      int         kind;
      logic [7:0] pos;
      logic       dir;
      int         cyc;
   } exp_t;

   exp_t q[$];
   exp_t e_mon;

   quad_decoder #(
      .FILT_LEN(4),
      .POS_W   (8),
      .HOLD    (10)
   ) dut (
      .CLK    (clk),
      .Reset_n(rst_n),
      .steerA (sa),
      .steerB (sb),
      .clr    (clr),
      .pos    (pos),
      .step   (step),
      .dir    (dir),
      .err    (err),
      .c_right(c_right),
      .c_left (c_left)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every step/err pulse must match the head of the queue.
   always @(negedge clk) begin
      if (rst_n && (step || err)) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event step=%0b err=%0b pos=%02h cyc=%0d",
                     step, err, pos, cyc);
         end else begin
            e_mon = q.pop_front();
            if ((step && err) ||
                (e_mon.kind == 1 && !step) ||
                (e_mon.kind == 2 && !err) ||
                pos !== e_mon.pos || dir !== e_mon.dir ||
                cyc != e_mon.cyc) begin
               errors++;
               $display("FAIL event got step=%0b err=%0b pos=%02h dir=%0b cyc=%0d want kind=%0d pos=%02h dir=%0b cyc=%0d",
                        step, err, pos, dir, cyc,
                        e_mon.kind, e_mon.pos, e_mon.dir, e_mon.cyc);
            end
         end
      end
      if (c_left || c_right) begin
         checks++;
         if (c_left && c_right) begin
            errors++;
            $display("FAIL both_held c_left=%0b c_right=%0b cyc=%0d",
                     c_left, c_right, cyc);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // kind: 0 = no event, 1 = step, 2 = err
   task automatic drive(input logic na, input logic nb, input int kind,
                        input logic [7:0] epos, input logic edir);
      exp_t e;
      @(negedge clk);
      sa = na;
      sb = nb;
      if (kind != 0) begin
         e.kind = kind;
         e.pos  = epos;
         e.dir  = edir;
         e.cyc  = cyc + LAT;
         q.push_back(e);
      end
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      idle(2);
   endtask

   int t0;
   int n;
   int hi;

   initial begin
      // Reset with inputs idle
      idle(50);
      chk("rst_pos", pos, 0);
      chk("rst_outs", {step, dir, err, c_right, c_left}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(20);
      chk("post_rst_pos", pos, 0);
      chk("post_rst_outs", {step, err, c_right, c_left}, 0);

      // Forward cycle 00->10->11->01->00
      drive(1, 0, 1, 8'h01, 1'b1);
      idle(20);
      drive(1, 1, X4 ? 1 : 0, 8'h02, 1'b1);
      idle(20);
      drive(0, 1, X4 ? 1 : 0, 8'h03, 1'b1);
      idle(20);
      drive(0, 0, X4 ? 1 : 0, 8'h04, 1'b1);
      idle(20);
      chk("fwd_cycle_pos", pos, X4 ? 8'h04 : 8'h01);
      chk("fwd_cycle_dir", dir, 1);

      pulse_clr();
      chk("clr_pos", pos, 0);

      // Reverse cycle from 0 wraps below zero
      drive(0, 1, X4 ? 1 : 0, 8'hFF, 1'b0);
      idle(20);
      drive(1, 1, X4 ? 1 : 0, 8'hFE, 1'b0);
      idle(20);
      drive(1, 0, X4 ? 1 : 0, 8'hFD, 1'b0);
      idle(20);
      drive(0, 0, 1, X4 ? 8'hFC : 8'hFF, 1'b0);
      idle(20);
      chk("rev_wrap_pos", pos, X4 ? 8'hFC : 8'hFF);
      chk("rev_wrap_dir", dir, 0);

      pulse_clr();

      // 3-cycle glitch on A must be filtered out
      @(negedge clk);
      sa = 1'b1;
      idle(3);
      sa = 1'b0;
      idle(20);
      chk("glitch_pos", pos, 0);
      chk("glitch_outs", {step, err}, 0);

      // Illegal jump 00->11, then normal counting
      drive(1, 1, 2, 8'h00, 1'b0);
      idle(20);
      chk("illegal_pos", pos, 0);
      drive(0, 1, X4 ? 1 : 0, 8'h01, 1'b1);
      idle(20);
      drive(0, 0, X4 ? 1 : 0, 8'h02, 1'b1);
      idle(20);
      chk("after_illegal_pos", pos, X4 ? 8'h02 : 8'h00);

      // Hold length after one forward step
      drive(1, 0, 1, X4 ? 8'h03 : 8'h01, 1'b1);
      n = 0;
      while (!c_right && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("c_right_rise", c_right, 1);
      chk("c_right_rise_lat", n, LAT);
      hi = 0;
      while (c_right && hi < 40) begin
         @(negedge clk);
         hi++;
      end
      chk("c_right_hold_len", hi, 10);
      chk("c_left_idle", c_left, 0);

      drive(0, 0, 1, X4 ? 8'h02 : 8'h00, 1'b0);
      idle(20);

      // Reverse step 5 cycles after a forward step swaps the levels
      drive(1, 0, 1, X4 ? 8'h03 : 8'h01, 1'b1);
      t0 = cyc;
      idle(4);
      drive(0, 0, 1, X4 ? 8'h02 : 8'h00, 1'b0);
      idle(t0 + 11 - cyc);
      chk("swap_before", {c_right, c_left}, 2'b10);
      idle(1);
      chk("swap_after", {c_right, c_left}, 2'b01);
      idle(20);

      // clr coinciding with a step: pos cleared, step still pulses
      drive(1, 0, 1, 8'h00, 1'b1);
      idle(6);
      clr = 1'b1;
      idle(1);
      clr = 1'b0;
      chk("clr_step_cright", c_right, 1);
      idle(20);
      chk("clr_step_pos", pos, 0);
      chk("clr_step_dir", dir, 1);

      chk("queue_empty", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/quad_decoder.md
Name: quad_decoder

Overview:
- Receive-side counterpart to the joystick-to-quadrature steering encoder.
- Decodes a 2-phase quadrature steering signal into a wrapping position count, step/direction pulses and held joystick-style left/right levels.
- Sources: a real spinner on USER_IN, or loopback from the encoder for self-test.
- Sits in the 12 MHz core domain, ahead of any core that wants position or joystick input instead of raw quadrature.

Parameters:
FILT_LEN  4      cycles a synchronized input must be stable before acceptance; 0 = filter bypassed
POS_W     8      position counter width
HOLD      45000  cycles c_left/c_right stay asserted after a counted step; matches encoder clkdiv

Ports:
CLK       in   1      core clock (clk_12)
Reset_n   in   1      asynchronous active-low reset
steerA    in   1      quadrature phase A, asynchronous
steerB    in   1      quadrature phase B, asynchronous
clr       in   1      synchronous clear of pos
pos       out  POS_W  position count, two's-complement, wraps
step      out  1      1-cycle pulse per counted step
dir       out  1      direction of last counted step: 1 = forward, 0 = reverse
err       out  1      1-cycle pulse on an illegal double transition
c_right   out  1      held level, forward motion
c_left    out  1      held level, reverse motion

Behaviour:
- Reset (async, Reset_n=0): every register and output goes to 0 (pos, step, dir, err, c_right, c_left, sync chain, filter, hold counter), and the valid flag is cleared.
- Reset mid-operation aborts any hold or filter count immediately. There is no count on exit from reset.
- Synchronizer: 2-FF chain per phase.
- Filter: per-phase counter.
  - Filtered bit updates only after the synchronized bit differs from it for FILT_LEN consecutive cycles.
  - Any bounce restarts that phase's counter.
  - FILT_LEN=0 passes the synchronized value straight through.
- Valid flag: the first filtered sample after reset is loaded as the previous state and sets valid. No step and no err are produced for that sample.
- Decoder: compares previous filtered {A,B} with current.
  - Forward sequence: 00->10->11->01->00 (A leads B).
  - Reverse sequence: the inverse of forward.
  - No change: nothing happens.
  - Illegal transition (both bits change, e.g. 00<->11, 10<->01): err pulses, pos unchanged, previous state updated to current.
- Counting: on each counted step
  - pos <= pos +/- 1, modulo 2^POS_W (0xFF+1 -> 0x00, 0x00-1 -> 0xFF);
  - step pulses for 1 cycle;
  - dir is updated.
- clr: if clr and a step coincide, clr wins (pos=0), but step, dir and the hold logic still act.
- Latency: asynchronous input edge to pos/step is exactly FILT_LEN+3 cycles (2 sync + FILT_LEN filter + 1 decode register). With FILT_LEN=0 it is 3.
- Hold logic: a counted step asserts c_right (forward) or c_left (reverse) and loads the hold counter with HOLD-1.
  - The output drops when the counter reaches 0, so it is high for exactly HOLD cycles after the last step.
  - A same-direction step retriggers (reloads) the counter.
  - An opposite-direction step deasserts the other output in the same cycle and starts a new hold.
  - c_left and c_right are never both 1.

Optional Feature:
- Macro: QUAD_X4_EN.
- Defined: x4 decode. Every legal transition counts, giving 4 counts per quadrature cycle.
- Undefined: x1 decode.
  - Only 00->10 counts +1 and only 10->00 counts -1.
  - All other legal transitions update the state silently.
  - Illegal transitions still pulse err.
- Hold, latency and err rules are identical in both builds.

Test Plan:
- Reset, then hold steerA=steerB=0 for 50 cycles, release Reset_n -> pos=0, no step, no err, c_left=c_right=0.
- Forward cycle 00->10->11->01->00, 20 cycles per state, FILT_LEN=4 -> x4: pos=4, 4 step pulses each 7 cycles after the input edge, dir=1. x1: pos=1.
- From pos=0x00, one reverse step (x1: 10->00 after 00->10->00) -> pos returns to 0x00. Starting from pos=0x00 with only a reverse x4 step 00->01 -> pos=0xFF, dir=0.
- 3-cycle glitch on steerA with FILT_LEN=4 -> pos, step and err unchanged.
- Jump 00->11 -> err single-cycle pulse, pos unchanged; a following 11->01 counts normally.
- HOLD=10: forward step -> c_right high exactly 10 cycles. Reverse step 5 cycles after the forward step -> c_right drops and c_left rises in the same cycle. Asserting clr together with a step -> pos=0 and step pulses.
